// File: rtl/capt_fwft_fifo_chksum.sv
// Capture-path buffer: 36x512 first-word-fall-through FIFO with registered status,
// plus an independent 16-bit ones'-complement checksum accumulator.
module capt_fwft_fifo_chksum #(
  parameter int DSIZE       = 36,
  parameter int DEPTH       = 512,
  parameter int AWIDTH      = 9,
  parameter int AFULL_LEVEL = 508
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WrEn,
  input  logic [DSIZE-1:0]  Data,
  output logic              Full,
  output logic              Almost_Full,
  input  logic              RdEn,
  output logic [DSIZE-1:0]  Q,
  output logic [AWIDTH:0]   Rnum,
  output logic              Empty,
  input  logic              chk_sum_rst,
  input  logic              chk_en,
  input  logic [15:0]       chk_data,
  output logic [15:0]       chk_sum
);

  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_C = (AWIDTH+1)'(AFULL_LEVEL);

  logic [DSIZE-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [DSIZE-1:0]  q_q, q_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic [15:0]       chk_sum_q, chk_sum_d;
  logic [16:0]       sum_s;
  logic              push_s, pop_s;

  // Acceptance uses the pre-edge registered flags.
  always_comb begin
    push_s = WrEn && !full_q;
    pop_s  = RdEn && !empty_q;
  end

  // Next pointer/count and status flags.
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1} : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AWIDTH{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AWIDTH{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    empty_d = (count_d == {(AWIDTH+1){1'b0}});
    full_d  = (count_d == DEPTH_C);
    afull_d = (count_d >= AFULL_C);
  end

  // Head word after this edge; the incoming word bypasses storage when it becomes the head.
  always_comb begin
    q_d = q_q;
    if (pop_s) begin
      if (count_q > {{(AWIDTH-1){1'b0}}, 2'd1}) begin
        q_d = mem[rd_ptr_q + {{(AWIDTH-1){1'b0}}, 1'b1}];
      end else if (push_s) begin
        q_d = Data;
      end else begin
        q_d = q_q;
      end
    end else if (push_s && empty_q) begin
      q_d = Data;
    end else begin
      q_d = q_q;
    end
  end

  // FIFO control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AWIDTH{1'b0}};
      rd_ptr_q <= {AWIDTH{1'b0}};
      count_q  <= {(AWIDTH+1){1'b0}};
      q_q      <= {DSIZE{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_q] <= Data;
    end
  end

  // Ones'-complement add with end-around carry; clear wins over accumulate.
  always_comb begin
    sum_s = {1'b0, chk_sum_q} + {1'b0, chk_data};
    if (chk_sum_rst) begin
      chk_sum_d = 16'd0;
    end else if (chk_en) begin
      chk_sum_d = sum_s[15:0] + {15'd0, sum_s[16]};
    end else begin
      chk_sum_d = chk_sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum_q <= 16'd0;
    end else begin
      chk_sum_q <= chk_sum_d;
    end
  end

  assign Q           = q_q;
  assign Rnum        = count_q;
  assign Empty       = empty_q;
  assign Full        = full_q;
  assign Almost_Full = afull_q;
  assign chk_sum     = chk_sum_q;

endmodule

// File: tb/tb_capt_fwft_fifo_chksum.sv
// Randomized bench for capt_fwft_fifo_chksum against a queue-based model of the FIFO
// and an arithmetic model of the ones'-complement checksum.
module tb_capt_fwft_fifo_chksum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WrEn, RdEn;
  logic [35:0] Data;
  logic        Full, Almost_Full, Empty;
  logic [35:0] Q;
  logic [9:0]  Rnum;
  logic        chk_sum_rst, chk_en;
  logic [15:0] chk_data;
  logic [15:0] chk_sum;

  capt_fwft_fifo_chksum dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Data(Data), .Full(Full),
    .Almost_Full(Almost_Full), .RdEn(RdEn), .Q(Q), .Rnum(Rnum), .Empty(Empty),
    .chk_sum_rst(chk_sum_rst), .chk_en(chk_en), .chk_data(chk_data), .chk_sum(chk_sum)
  );

  always #5 clk = ~clk;

  logic [35:0] fifo_m [$];
  logic [35:0] head_m;
  int unsigned chk_m;
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    int n;
    n = fifo_m.size();
    check("empty", 64'(Empty), 64'(n == 0));
    check("full", 64'(Full), 64'(n == 512));
    check("almost_full", 64'(Almost_Full), 64'(n >= 508));
    check("rnum", 64'(Rnum), 64'(n));
    check("q", 64'(Q), 64'(head_m));
    check("chk_sum", 64'(chk_sum), 64'(chk_m));
  endtask

  task automatic model_reset();
    fifo_m.delete();
    head_m = 36'd0;
    chk_m  = 0;
  endtask

  function automatic logic [35:0] rnd_word();
    return {4'($urandom_range(15)), 32'($urandom)};
  endfunction

  // One clock: drive inputs, advance model on the edge, compare just after it.
  task automatic cycle(input logic wr, input logic [35:0] d, input logic rd,
                       input logic cr, input logic ce, input logic [15:0] cd);
    bit push_ok, pop_ok;
    int unsigned s;
    WrEn = wr; Data = d; RdEn = rd; chk_sum_rst = cr; chk_en = ce; chk_data = cd;
    @(posedge clk);
    push_ok = wr && (fifo_m.size() < 512);
    pop_ok  = rd && (fifo_m.size() > 0);
    if (pop_ok)  void'(fifo_m.pop_front());
    if (push_ok) fifo_m.push_back(d);
    if (fifo_m.size() > 0) head_m = fifo_m[0];
    if (cr) chk_m = 0;
    else if (ce) begin
      s = chk_m + 32'(cd);
      chk_m = (s & 32'hFFFF) + (s >> 16);
    end
    #1;
    check_all();
  endtask

  task automatic rcycle(input logic wr, input logic rd);
    cycle(wr, rnd_word(), rd, ($urandom_range(31) == 0), 1'($urandom), 16'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Data = 36'd0;
    chk_sum_rst = 1'b0; chk_en = 1'b0; chk_data = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 64'(Empty), 64'd1);
    check("rst_rnum", 64'(Rnum), 64'd0);
    check("rst_q", 64'(Q), 64'd0);
    check("rst_chk", 64'(chk_sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic order
    for (int i = 1; i <= 3; i++) cycle(1'b1, 36'(i), 1'b0, 1'b0, 1'b0, 16'd0);
    check("t1_q_first", 64'(Q), 64'd1);
    check("t1_rnum3", 64'(Rnum), 64'd3);
    cycle(1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    check("t1_q_second", 64'(Q), 64'd2);
    cycle(1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    check("t1_q_third", 64'(Q), 64'd3);
    cycle(1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    check("t1_empty", 64'(Empty), 64'd1);
    check("t1_q_hold", 64'(Q), 64'd3);

    // Fill to full, overflow attempt, drain
    for (int i = 0; i < 512; i++) cycle(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 16'd0);
    check("t2_full", 64'(Full), 64'd1);
    check("t2_rnum512", 64'(Rnum), 64'd512);
    cycle(1'b1, 36'hF_DEADBEEF, 1'b0, 1'b0, 1'b0, 16'd0);
    check("t2_rnum_after_drop", 64'(Rnum), 64'd512);
    for (int i = 0; i < 512; i++) cycle(1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 16'd0);

    // Five resident words, long simultaneous stream across several wraps
    for (int i = 0; i < 5; i++) rcycle(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) rcycle(1'b1, 1'b1);
    check("t3_rnum5", 64'(Rnum), 64'd5);
    for (int i = 0; i < 5; i++) rcycle(1'b0, 1'b1);

    // Read while empty, then push+pop at full
    for (int i = 0; i < 4; i++) cycle(1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 512; i++) rcycle(1'b1, 1'b0);
    cycle(1'b1, 36'h5_A5A5A5A5, 1'b1, 1'b0, 1'b0, 16'd0);
    check("t4_rnum511", 64'(Rnum), 64'd511);
    for (int i = 0; i < 511; i++) rcycle(1'b0, 1'b1);

    // Checksum end-around carry and clear priority
    cycle(1'b0, 36'd0, 1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 36'd0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    check("t5_ffff", 64'(chk_sum), 64'hFFFF);
    cycle(1'b0, 36'd0, 1'b0, 1'b0, 1'b1, 16'h0002);
    check("t5_carry", 64'(chk_sum), 64'h0002);
    cycle(1'b0, 36'd0, 1'b0, 1'b1, 1'b1, 16'h1234);
    check("t5_clear_prio", 64'(chk_sum), 64'h0000);

    // Random mixed traffic
    for (int i = 0; i < 3000; i++) rcycle(($urandom_range(99) < 55), ($urandom_range(99) < 50));

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 20; i++) rcycle(1'b1, 1'($urandom));
    cycle(1'b0, 36'd0, 1'b0, 1'b0, 1'b1, 16'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_empty", 64'(Empty), 64'd1);
    check("t6_rnum", 64'(Rnum), 64'd0);
    check("t6_chk", 64'(chk_sum), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) rcycle(1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
